request_decoder: RTL and testbench

Receive-side counterpart of the sensor response path. Consumes bytes delivered by the UART receiver, assembles two-byte request frames (request code, then sensor address), validates them, and presents one decoded request at a time to the sensor control logic through a valid/ack handshake. Malformed or stalled frames are discarded and reported through a one-cycle error pulse.

---
 rtl/request_pkg.sv | 36 +++
 rtl/frame_timer.sv | 40 ++++
 rtl/request_decoder.sv | 145 ++++++++++++++
 tb/tb_request_decoder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/request_pkg.sv
// Shared definitions for the sensor request path: FSM encoding, error reasons
// and the request code map also used by the response side.
package request_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WAIT_ADDR = 2'b01,
        ST_PENDING   = 2'b10
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CODE    = 2'b01;
    localparam logic [1:0] ERR_ADDR    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] REQ_CODE_00 = 8'h00;
    localparam logic [7:0] REQ_CODE_01 = 8'h01;
    localparam logic [7:0] REQ_CODE_02 = 8'h02;
    localparam logic [7:0] REQ_CODE_03 = 8'h03;
    localparam logic [7:0] REQ_CODE_04 = 8'h04;
    localparam logic [7:0] REQ_CODE_05 = 8'h05;
    localparam logic [7:0] REQ_CODE_06 = 8'h06;
    localparam logic [7:0] REQ_CODE_07 = 8'h07;
    localparam logic [7:0] REQ_CODE_08 = 8'h08;
    localparam logic [7:0] REQ_CODE_MAX = REQ_CODE_08;

    function automatic logic code_is_legal(input logic [7:0] b, input logic [7:0] max_code);
        return b <= max_code;
    endfunction

    // An address byte is legal when no bit above the address field is set.
    function automatic logic addr_fits(input logic [7:0] b, input int unsigned addr_width);
        return (b >> addr_width) == 8'h00;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte watchdog for the request decoder: counts cycles while enabled and
// flags the last allowed cycle; only built when REQUEST_TIMEOUT_EN is defined.
module frame_timer
    import request_pkg::*;
#(
    parameter int unsigned CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/request_decoder.sv
// Assembles {code, address} byte pairs from the UART into one pending request
// with valid/ack handshake. Define REQUEST_TIMEOUT_EN for the inter-byte timeout.
module request_decoder
    import request_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter logic [7:0]  MAX_CODE       = REQ_CODE_MAX,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  has_data,
    input  logic [7:0]            data_received,
    input  logic                  request_ack,
    output logic                  request_valid,
    output logic [7:0]            request_code,
    output logic [ADDR_WIDTH-1:0] sensor_address,
    output logic                  error_valid,
    output logic [1:0]            error_code,
    output logic                  byte_dropped
);

    state_e                state_q, state_d;
    logic [7:0]            code_byte_q, code_byte_d;
    logic                  request_valid_q, request_valid_d;
    logic [7:0]            request_code_q, request_code_d;
    logic [ADDR_WIDTH-1:0] sensor_address_q, sensor_address_d;
    logic                  error_valid_q, error_valid_d;
    logic [1:0]            error_code_q, error_code_d;
    logic                  byte_dropped_q, byte_dropped_d;

`ifdef REQUEST_TIMEOUT_EN
    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    // Restart the window on the same edge that moves us into WAIT_ADDR.
    assign timer_clear  = (state_q == ST_IDLE) && has_data
                          && code_is_legal(data_received, MAX_CODE);
    assign timer_enable = (state_q == ST_WAIT_ADDR);

    frame_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_frame_timer (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .clear_i   (timer_clear),
        .enable_i  (timer_enable),
        .expired_o (timer_expired)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d          = state_q;
        code_byte_d      = code_byte_q;
        request_valid_d  = request_valid_q;
        request_code_d   = request_code_q;
        sensor_address_d = sensor_address_q;
        error_valid_d    = 1'b0;
        error_code_d     = ERR_NONE;
        byte_dropped_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (has_data) begin
                    if (code_is_legal(data_received, MAX_CODE)) begin
                        code_byte_d = data_received;
                        state_d     = ST_WAIT_ADDR;
                    end else begin
                        error_valid_d = 1'b1;
                        error_code_d  = ERR_CODE;
                    end
                end
            end

            ST_WAIT_ADDR: begin
                if (has_data) begin
                    if (addr_fits(data_received, ADDR_WIDTH)) begin
                        request_code_d   = code_byte_q;
                        sensor_address_d = data_received[ADDR_WIDTH-1:0];
                        request_valid_d  = 1'b1;
                        state_d          = ST_PENDING;
                    end else begin
                        error_valid_d = 1'b1;
                        error_code_d  = ERR_ADDR;
                        state_d       = ST_IDLE;
                    end
`ifdef REQUEST_TIMEOUT_EN
                end else if (timer_expired) begin
                    error_valid_d = 1'b1;
                    error_code_d  = ERR_TIMEOUT;
                    state_d       = ST_IDLE;
`endif
                end
            end

            ST_PENDING: begin
                // A byte landing here is lost even if the ack arrives together.
                byte_dropped_d = has_data;
                if (request_ack) begin
                    request_valid_d = 1'b0;
                    state_d         = ST_IDLE;
                end
            end

            default: begin
                state_d         = ST_IDLE;
                request_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            code_byte_q      <= 8'h00;
            request_valid_q  <= 1'b0;
            request_code_q   <= 8'h00;
            sensor_address_q <= '0;
            error_valid_q    <= 1'b0;
            error_code_q     <= ERR_NONE;
            byte_dropped_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            code_byte_q      <= code_byte_d;
            request_valid_q  <= request_valid_d;
            request_code_q   <= request_code_d;
            sensor_address_q <= sensor_address_d;
            error_valid_q    <= error_valid_d;
            error_code_q     <= error_code_d;
            byte_dropped_q   <= byte_dropped_d;
        end
    end

    assign request_valid  = request_valid_q;
    assign request_code   = request_code_q;
    assign sensor_address = sensor_address_q;
    assign error_valid    = error_valid_q;
    assign error_code     = error_code_q;
    assign byte_dropped   = byte_dropped_q;

endmodule

// File: tb/tb_request_decoder.sv
// Self-checking bench for request_decoder: vector table plus timeout / idle-wait
// sequences; expected outputs queued at drive time and compared after the edge.
module tb_request_decoder;

    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          has_data = 1'b0;
    logic [7:0]    data_received = 8'h00;
    logic          request_ack = 1'b0;
    logic          request_valid;
    logic [7:0]    request_code;
    logic [AW-1:0] sensor_address;
    logic          error_valid;
    logic [1:0]    error_code;
    logic          byte_dropped;

    always #5 clock = ~clock;

    request_decoder #(
        .ADDR_WIDTH     (AW),
        .MAX_CODE       (8'h08),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .has_data       (has_data),
        .data_received  (data_received),
        .request_ack    (request_ack),
        .request_valid  (request_valid),
        .request_code   (request_code),
        .sensor_address (sensor_address),
        .error_valid    (error_valid),
        .error_code     (error_code),
        .byte_dropped   (byte_dropped)
    );

    typedef struct packed {
        logic          rv;
        logic [7:0]    code;
        logic [AW-1:0] addr;
        logic          ev;
        logic [1:0]    ec;
        logic          bd;
    } exp_t;

    typedef struct {
        logic       rst_n;
        logic       hd;
        logic [7:0] d;
        logic       ack;
        exp_t       e;
        string      name;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(logic rv, logic [7:0] c, logic [AW-1:0] a,
                                logic ev, logic [1:0] ec, logic bd);
        exp_t e;
        e.rv = rv; e.code = c; e.addr = a; e.ev = ev; e.ec = ec; e.bd = bd;
        return e;
    endfunction

    function automatic void add(logic rn, logic hd, logic [7:0] d, logic ack,
                                exp_t e, string n);
        vec_t t;
        t.rst_n = rn; t.hd = hd; t.d = d; t.ack = ack; t.e = e; t.name = n;
        vecs.push_back(t);
    endfunction

    task automatic compare(input string name);
        exp_t got, want;
        got = '{request_valid, request_code, sensor_address, error_valid, error_code, byte_dropped};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got rv=%0b code=%h addr=%0d", name,
                     got.rv, got.code, got.addr);
        end else begin
            want = sb.pop_front();
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got rv=%0b code=%h addr=%0d ev=%0b ec=%b bd=%0b, expected rv=%0b code=%h addr=%0d ev=%0b ec=%b bd=%0b",
                         name, got.rv, got.code, got.addr, got.ev, got.ec, got.bd,
                         want.rv, want.code, want.addr, want.ev, want.ec, want.bd);
            end
        end
    endtask

    task automatic step(input logic rn, input logic hd, input logic [7:0] d,
                        input logic ack, input exp_t e, input string name);
        @(negedge clock);
        reset_n       = rn;
        has_data      = hd;
        data_received = d;
        request_ack   = ack;
        sb.push_back(e);
        @(posedge clock);
        #1;
        compare(name);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // rst_n, has_data, data, ack | rv, code, addr, ev, ec, bd
        add(0, 0, 8'h00, 0, mk(0, 8'h00,  0, 0, 2'b00, 0), "reset_state");
        add(0, 1, 8'h01, 1, mk(0, 8'h00,  0, 0, 2'b00, 0), "reset_ignores_inputs");
        add(1, 1, 8'h01, 0, mk(0, 8'h00,  0, 0, 2'b00, 0), "code_01");
        add(1, 1, 8'h05, 0, mk(1, 8'h01,  5, 0, 2'b00, 0), "addr_05_valid");
        add(1, 0, 8'h00, 0, mk(1, 8'h01,  5, 0, 2'b00, 0), "pending_held");
        add(1, 0, 8'h00, 1, mk(0, 8'h01,  5, 0, 2'b00, 0), "ack_clears_valid");
        add(1, 1, 8'h09, 0, mk(0, 8'h01,  5, 1, 2'b01, 0), "bad_code_09");
        add(1, 1, 8'h02, 0, mk(0, 8'h01,  5, 0, 2'b00, 0), "error_one_cycle");
        add(1, 1, 8'h1F, 0, mk(1, 8'h02, 31, 0, 2'b00, 0), "addr_31_valid");
        add(1, 0, 8'h00, 1, mk(0, 8'h02, 31, 0, 2'b00, 0), "ack_2");
        add(1, 1, 8'h03, 0, mk(0, 8'h02, 31, 0, 2'b00, 0), "code_03");
        add(1, 1, 8'h20, 0, mk(0, 8'h02, 31, 1, 2'b10, 0), "bad_addr_20");
        add(1, 1, 8'h07, 0, mk(0, 8'h02, 31, 0, 2'b00, 0), "fresh_code_07");
        add(1, 1, 8'h00, 0, mk(1, 8'h07,  0, 0, 2'b00, 0), "addr_00_valid");
        add(1, 1, 8'h04, 1, mk(0, 8'h07,  0, 0, 2'b00, 1), "ack_with_byte_dropped");
        add(1, 1, 8'h00, 0, mk(0, 8'h07,  0, 0, 2'b00, 0), "code_00_after_drop");
        add(1, 1, 8'h01, 0, mk(1, 8'h00,  1, 0, 2'b00, 0), "addr_01_valid");
        add(1, 1, 8'h06, 0, mk(1, 8'h00,  1, 0, 2'b00, 1), "drop_while_pending");
        add(1, 0, 8'h00, 0, mk(1, 8'h00,  1, 0, 2'b00, 0), "drop_one_cycle");
        add(1, 0, 8'h00, 1, mk(0, 8'h00,  1, 0, 2'b00, 0), "ack_3");
        add(1, 0, 8'h00, 1, mk(0, 8'h00,  1, 0, 2'b00, 0), "stray_ack_idle");
        add(1, 1, 8'hFF, 0, mk(0, 8'h00,  1, 1, 2'b01, 0), "bad_code_ff");
        add(1, 1, 8'h08, 0, mk(0, 8'h00,  1, 0, 2'b00, 0), "max_code_08");
        add(1, 1, 8'h1F, 0, mk(1, 8'h08, 31, 0, 2'b00, 0), "max_code_request");
        add(1, 0, 8'h00, 1, mk(0, 8'h08, 31, 0, 2'b00, 0), "ack_4");
        add(1, 1, 8'h01, 0, mk(0, 8'h08, 31, 0, 2'b00, 0), "code_before_reset");
        add(0, 0, 8'h00, 0, mk(0, 8'h00,  0, 0, 2'b00, 0), "midframe_reset");
        add(1, 1, 8'h06, 0, mk(0, 8'h00,  0, 0, 2'b00, 0), "code_06_after_reset");
        add(1, 1, 8'h02, 0, mk(1, 8'h06,  2, 0, 2'b00, 0), "addr_02_valid");
        add(1, 0, 8'h00, 1, mk(0, 8'h06,  2, 0, 2'b00, 0), "ack_5");

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].hd, vecs[i].d, vecs[i].ack, vecs[i].e, vecs[i].name);
        end

`ifdef REQUEST_TIMEOUT_EN
        // Silence after a code byte: error on the 16th edge after WAIT_ADDR entry.
        step(1, 1, 8'h01, 0, mk(0, 8'h06, 2, 0, 2'b00, 0), "to_code");
        for (int i = 1; i < 16; i++) begin
            step(1, 0, 8'h00, 0, mk(0, 8'h06, 2, 0, 2'b00, 0), "to_waiting");
        end
        step(1, 0, 8'h00, 0, mk(0, 8'h06, 2, 1, 2'b11, 0), "to_error");
        step(1, 0, 8'h00, 0, mk(0, 8'h06, 2, 0, 2'b00, 0), "to_error_one_cycle");
        // Address byte on that same last cycle wins over the timeout.
        step(1, 1, 8'h01, 0, mk(0, 8'h06, 2, 0, 2'b00, 0), "to_code_2");
        for (int i = 1; i < 16; i++) begin
            step(1, 0, 8'h00, 0, mk(0, 8'h06, 2, 0, 2'b00, 0), "to_waiting_2");
        end
        step(1, 1, 8'h05, 0, mk(1, 8'h01, 5, 0, 2'b00, 0), "to_addr_last_cycle");
        step(1, 0, 8'h00, 1, mk(0, 8'h01, 5, 0, 2'b00, 0), "to_ack");
`else
        // Without the timer WAIT_ADDR waits indefinitely.
        step(1, 1, 8'h01, 0, mk(0, 8'h06, 2, 0, 2'b00, 0), "wait_code");
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 8'h00, 0, mk(0, 8'h06, 2, 0, 2'b00, 0), "wait_no_timeout");
        end
        step(1, 1, 8'h05, 0, mk(1, 8'h01, 5, 0, 2'b00, 0), "wait_addr_late");
        step(1, 0, 8'h00, 1, mk(0, 8'h01, 5, 0, 2'b00, 0), "wait_ack");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
